// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline stall/bubble controller.
package pipe_ctrl_pkg;

   // Mul/div sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   localparam int MUL_LAT_DEF = 3;
   localparam int DIV_LAT_DEF = 32;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// md_seq: mul/div sequencer for the E stage. Holds E while the multi-cycle
// unit works, then raises md_ready for as long as E stays frozen in DONE.
// Instantiated by pipe_ctrl only when PIPE_CTRL_MULDIV_EN is defined.
module md_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      md_start_e,
   input  logic      md_div_e,
   input  logic      d_busy,
   output logic      mdw,
   output logic      md_ready,
   output logic      md_busy,
   output md_state_t o_state
);

   localparam int CNT_RAW = $clog2(max_int(MUL_LAT, DIV_LAT));
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   md_state_t        r_state;
   md_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // State and latency counter registers; reset abandons any operation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: a start seen while d_busy is high is retried next cycle;
   // BUSY counts down to 0 regardless of d_busy; DONE waits for E to advance
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (md_start_e && !d_busy) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = md_div_e ? DIV_LOAD : MUL_LOAD;
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DONE: begin
            // In DONE the only E stall source is d_busy
            if (!d_busy) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign mdw      = ((r_state == IDLE) && md_start_e) || (r_state == BUSY);
   assign md_ready = (r_state == DONE);
   assign md_busy  = (r_state != IDLE);
   assign o_state  = r_state;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage-enable and bubble control for the 5-stage F/D/E/M/W pipe.
// Covers load-use hazards, data/instruction memory freezes and, when
// PIPE_CTRL_MULDIV_EN is defined, the multi-cycle mul/div unit in E.
// Without PIPE_CTRL_MULDIV_EN mul/div is treated as single-cycle.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic       uses_rs_d,
   input  logic       uses_rt_d,
   input  logic [4:0] rd_e,
   input  logic       load_e,
   input  logic       md_start_e,
   input  logic       md_div_e,
   input  logic       i_busy,
   input  logic       d_busy,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       stall_m,
   output logic       flush_e,
   output logic       flush_m,
   output logic       flush_w,
   output logic       md_ready,
   output logic       md_busy
);

   logic w_lu;
   logic w_mdw;

`ifdef PIPE_CTRL_MULDIV_EN
   md_state_t w_unused_md_state;

   md_seq #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_seq (
      .clk        (clk),
      .reset      (reset),
      .md_start_e (md_start_e),
      .md_div_e   (md_div_e),
      .d_busy     (d_busy),
      .mdw        (w_mdw),
      .md_ready   (md_ready),
      .md_busy    (md_busy),
      .o_state    (w_unused_md_state)
   );
`else
   logic w_unused;

   assign w_mdw    = 1'b0;
   assign md_ready = 1'b0;
   assign md_busy  = 1'b0;
   // clk/reset only feed the sequencer, which is absent in this build
   assign w_unused = &{1'b0, clk, reset, md_start_e, md_div_e,
                       (MUL_LAT > 0), (DIV_LAT > 0)};
`endif

   // Load-use: the E load's result is not forwardable to D this cycle; $zero never hazards
   assign w_lu = load_e &
                 ((uses_rs_d & (rs_d != 5'd0) & (rs_d == rd_e)) |
                  (uses_rt_d & (rt_d != 5'd0) & (rt_d == rd_e)));

   // Stalls cascade upstream; i_busy only freezes F
   assign stall_m = d_busy;
   assign stall_e = d_busy | w_mdw;
   assign stall_d = stall_e | w_lu;
   assign stall_f = stall_d | i_busy;

   // Bubbles go into the stage just below the lowest held stage
   assign flush_w = d_busy;
   assign flush_m = w_mdw & ~d_busy;
   assign flush_e = w_lu & ~stall_e;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl. Mul/div sequences run only when
// PIPE_CTRL_MULDIV_EN is defined; otherwise md_start_e must have no effect.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] rs_d, rt_d, rd_e;
   logic uses_rs_d, uses_rt_d, load_e, md_start_e, md_div_e, i_busy, d_busy;
   logic stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, flush_w;
   logic md_ready, md_busy;

   pipe_ctrl #(.MUL_LAT(MUL_LAT_DEF), .DIV_LAT(DIV_LAT_DEF)) dut (
      .clk(clk), .reset(reset),
      .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
      .rd_e(rd_e), .load_e(load_e), .md_start_e(md_start_e), .md_div_e(md_div_e),
      .i_busy(i_busy), .d_busy(d_busy),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
      .md_ready(md_ready), .md_busy(md_busy)
   );

   // {stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, flush_w}
   logic [6:0] w_out;
   assign w_out = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, flush_w};

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0] rs, rt, rd;
      logic       urs, urt, ld, ib, db;
      logic [6:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic urs, input logic urt,
                               input logic ld, input logic ib, input logic db,
                               input logic [6:0] exp);
      vec_t v;
      v.rs = rs; v.rt = rt; v.rd = rd; v.urs = urs; v.urt = urt;
      v.ld = ld; v.ib = ib; v.db = db; v.exp = exp;
      return v;
   endfunction

   task automatic idle_inputs();
      rs_d = '0; rt_d = '0; rd_e = '0; uses_rs_d = 0; uses_rt_d = 0; load_e = 0;
      md_start_e = 0; md_div_e = 0; i_busy = 0; d_busy = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Mul/div run: d_busy for 'pre' cycles before the start is accepted and for
   // 'hold' cycles once in DONE. Expected waveform follows the timing rules.
   task automatic md_run(input string tag, input logic div, input int lat,
                         input int pre, input int hold);
      int t, adv;
      logic db;
      logic [6:0] e;
      t = pre;
      adv = t + lat + 1 + hold;
      for (int k = 0; k <= adv + 1; k++) begin
         @(posedge clk); #1;
         db = (k < pre) || (k >= t + lat + 1 && k <= t + lat + hold);
         d_busy = db;
         md_start_e = (k <= adv);
         md_div_e = div;
         @(negedge clk);
         e[6] = db | (k <= t + lat);           // stall_f
         e[5] = db | (k <= t + lat);           // stall_d
         e[4] = db | (k <= t + lat);           // stall_e
         e[3] = db;                            // stall_m
         e[2] = 1'b0;                          // flush_e
         e[1] = (k <= t + lat) & ~db;          // flush_m
         e[0] = db;                            // flush_w
         chk($sformatf("%s ctl k=%0d", tag, k), 32'(w_out), 32'(e));
         chk($sformatf("%s rdy k=%0d", tag, k), 32'(md_ready),
             32'((k >= t + lat + 1) && (k <= adv)));
         chk($sformatf("%s bsy k=%0d", tag, k), 32'(md_busy),
             32'((k >= t + 1) && (k <= adv)));
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   vec_t vecs[12];

   initial begin
      logic seen;
      idle_inputs();

      // reset state
      #2;
      chk("reset ctl", 32'(w_out), 32'h0);
      chk("reset rdy", 32'(md_ready), 32'h0);
      chk("reset bsy", 32'(md_busy), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      //            rs     rt     rd     urs urt ld ib db  expected
      vecs[0]  = mk(5'd0,  5'd0,  5'd0,  0,  0,  0, 0, 0, 7'b0000_000);
      vecs[1]  = mk(5'd5,  5'd0,  5'd5,  1,  0,  1, 0, 0, 7'b1100_100);
      vecs[2]  = mk(5'd1,  5'd7,  5'd7,  0,  1,  1, 0, 0, 7'b1100_100);
      vecs[3]  = mk(5'd0,  5'd0,  5'd0,  1,  1,  1, 0, 0, 7'b0000_000);
      vecs[4]  = mk(5'd5,  5'd0,  5'd5,  0,  0,  1, 0, 0, 7'b0000_000);
      vecs[5]  = mk(5'd5,  5'd0,  5'd5,  1,  0,  0, 0, 0, 7'b0000_000);
      vecs[6]  = mk(5'd0,  5'd0,  5'd0,  0,  0,  0, 1, 0, 7'b1000_000);
      vecs[7]  = mk(5'd0,  5'd0,  5'd0,  0,  0,  0, 0, 1, 7'b1111_001);
      vecs[8]  = mk(5'd9,  5'd0,  5'd9,  1,  0,  1, 0, 1, 7'b1111_001);
      vecs[9]  = mk(5'd9,  5'd0,  5'd9,  1,  0,  1, 1, 0, 7'b1100_100);
      vecs[10] = mk(5'd5,  5'd0,  5'd6,  1,  0,  1, 0, 0, 7'b0000_000);
      vecs[11] = mk(5'd3,  5'd31, 5'd31, 1,  1,  1, 0, 0, 7'b1100_100);

      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         rs_d = vecs[i].rs; rt_d = vecs[i].rt; rd_e = vecs[i].rd;
         uses_rs_d = vecs[i].urs; uses_rt_d = vecs[i].urt; load_e = vecs[i].ld;
         i_busy = vecs[i].ib; d_busy = vecs[i].db;
         @(negedge clk);
         chk($sformatf("vec%0d ctl", i), 32'(w_out), 32'(vecs[i].exp));
         chk($sformatf("vec%0d rdy", i), 32'(md_ready), 32'h0);
      end

      // load-use costs one bubble: next cycle E holds the bubble, D proceeds
      @(posedge clk); #1;
      idle_inputs();
      load_e = 1; rd_e = 5'd5; rs_d = 5'd5; uses_rs_d = 1;
      @(negedge clk);
      chk("lu cyc0", 32'(w_out), 32'(7'b1100_100));
      @(posedge clk); #1;
      load_e = 0; rd_e = 5'd0;
      @(negedge clk);
      chk("lu cyc1", 32'(w_out), 32'h0);

`ifdef PIPE_CTRL_MULDIV_EN
      md_run("mul", 1'b0, MUL_LAT_DEF, 0, 0);
      md_run("div", 1'b1, DIV_LAT_DEF, 0, 0);
      md_run("mul_done_hold", 1'b0, MUL_LAT_DEF, 0, 2);
      md_run("mul_issue_dbusy", 1'b0, MUL_LAT_DEF, 2, 0);

      // lu together with mdw: mdw wins, no E bubble
      @(posedge clk); #1;
      idle_inputs();
      load_e = 1; rd_e = 5'd4; rt_d = 5'd4; uses_rt_d = 1; md_start_e = 1;
      @(negedge clk);
      chk("lu_mdw ctl", 32'(w_out), 32'(7'b1110_010));
      do_reset();

      // reset while dividing with counter at 10
      @(posedge clk); #1;
      md_start_e = 1; md_div_e = 1;
      repeat (22) @(posedge clk);
      #1;
      reset = 1'b1; md_start_e = 0; md_div_e = 0;
      #1;
      chk("rst_busy ctl", 32'(w_out), 32'h0);
      chk("rst_busy bsy", 32'(md_busy), 32'h0);
      chk("rst_busy rdy", 32'(md_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (md_ready || md_busy) seen = 1'b1;
      end
      chk("rst_busy no_ready", 32'(seen), 32'h0);
`else
      // mul/div is single-cycle: md_start_e has no effect
      @(posedge clk); #1;
      idle_inputs();
      md_start_e = 1; md_div_e = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("nomd ctl k=%0d", k), 32'(w_out), 32'h0);
         chk($sformatf("nomd rdy k=%0d", k), 32'(md_ready), 32'h0);
         chk($sformatf("nomd bsy k=%0d", k), 32'(md_busy), 32'h0);
         if (k == 1) md_div_e = 0;
      end
      // d_busy with md_start_e: only the memory freeze shows
      @(posedge clk); #1;
      d_busy = 1;
      @(negedge clk);
      chk("nomd dbusy ctl", 32'(w_out), 32'(7'b1111_001));
      do_reset();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Overall time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
